// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU function codes, slice op codes and issue-stage types.
// No logic here; imported by the issue stage and its control decoder.
// Backpressure: n/a.
package alu_issue_stage_pkg;

  localparam int DEF_WIDTH     = 24;
  localparam int DEF_IMM_WIDTH = 12;

  localparam logic [3:0] FN_AND = 4'd0;
  localparam logic [3:0] FN_OR  = 4'd1;
  localparam logic [3:0] FN_ADD = 4'd2;
  localparam logic [3:0] FN_SUB = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLT = 4'd5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       binvert;
    logic       cin;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Translates an ALU function code into 1-bit-slice controls.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module alu_control_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [3:0] AluFunct,
  output logic [2:0] Op,
  output logic       BInvert,
  output logic       CIN,
  output logic       Illegal
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '{op: OP_AND, binvert: 1'b0, cin: 1'b0, illegal: 1'b0};
    case (AluFunct)
      FN_AND: ctrl.op = OP_AND;
      FN_OR:  ctrl.op = OP_OR;
      FN_ADD: ctrl.op = OP_ADD;
      // Subtraction is A + ~B + 1; the slices do the inversion.
      FN_SUB: ctrl = '{op: OP_ADD, binvert: 1'b1, cin: 1'b1, illegal: 1'b0};
      FN_XOR: ctrl.op = OP_XOR;
      FN_SLT: ctrl = '{op: OP_SLT, binvert: 1'b1, cin: 1'b1, illegal: 1'b0};
      default: ctrl.illegal = 1'b1;
    endcase
  end

  assign Op      = ctrl.op;
  assign BInvert = ctrl.binvert;
  assign CIN     = ctrl.cin;
  assign Illegal = ctrl.illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the slice ALU: B-operand select, control decode, one register slot.
// Latency: one cycle from accept to OutValid.
// Backpressure: valid/ready; InReady = ~OutValid | OutReady so a full slot streams at 1/cycle.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Flush,
  input  logic [3:0]           AluFunct,
  input  logic                 UseImm,
  input  logic [WIDTH-1:0]     RegA,
  input  logic [WIDTH-1:0]     RegB,
  input  logic [IMM_WIDTH-1:0] Imm,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [2:0]           Op,
  output logic                 BInvert,
  output logic                 CIN,
  output logic                 Illegal
);

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] imm_sext;
  ctrl_t            dec;
  ctrl_t            ctrl_q;

  alu_control_decode u_decode (
    .AluFunct (AluFunct),
    .Op       (dec.op),
    .BInvert  (dec.binvert),
    .CIN      (dec.cin),
    .Illegal  (dec.illegal)
  );

  assign imm_sext = {{(WIDTH-IMM_WIDTH){Imm[IMM_WIDTH-1]}}, Imm};
  assign b_sel    = UseImm ? imm_sext : RegB;

  assign OutValid = (state == ST_FULL);
  assign InReady  = ~OutValid | OutReady;
  assign accept   = InValid & InReady & ~Flush;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL: begin
        if (Flush)               state_nxt = ST_EMPTY;
        else if (accept)         state_nxt = ST_FULL;
        else if (OutReady)       state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Data registers only move on accept, so a stall keeps every field stable.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      A      <= '0;
      B      <= '0;
      ctrl_q <= '0;
    end else if (accept) begin
      A      <= RegA;
      B      <= b_sel;
      ctrl_q <= dec;
    end else if (Flush) begin
      ctrl_q.illegal <= 1'b0;
    end
  end

  assign Op      = ctrl_q.op;
  assign BInvert = ctrl_q.binvert;
  assign CIN     = ctrl_q.cin;
  assign Illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus random stimulus for alu_issue_stage, checked against a cycle-level
// behavioural model built from the function table and handshake rules.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [3:0]  funct;
  logic        use_imm;
  logic [23:0] reg_a;
  logic [23:0] reg_b;
  logic [11:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] a_q;
  logic [23:0] b_q;
  logic [2:0]  op_q;
  logic        binv_q;
  logic        cin_q;
  logic        ill_q;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .Clock    (clk),
    .Reset    (rst),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .Flush    (flush),
    .AluFunct (funct),
    .UseImm   (use_imm),
    .RegA     (reg_a),
    .RegB     (reg_b),
    .Imm      (imm),
    .OutValid (out_valid),
    .OutReady (out_ready),
    .A        (a_q),
    .B        (b_q),
    .Op       (op_q),
    .BInvert  (binv_q),
    .CIN      (cin_q),
    .Illegal  (ill_q)
  );

  always #5 clk = ~clk;

  // Reference function table, written straight from the opcode list.
  logic [2:0] t_op   [16];
  logic       t_binv [16];
  logic       t_cin  [16];
  logic       t_ill  [16];

  // Model of the held entry; m_det says whether data fields are defined right now.
  logic        m_vld, m_ill, m_binv, m_cin, m_det, m_ill_det;
  logic [23:0] m_a, m_b;
  logic [2:0]  m_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] sext12(input logic [11:0] v);
    int unsigned u;
    u = v;
    if (u >= 2048) u = u + 32'h00FF_F000;
    return u[23:0];
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".inready"}, {31'd0, in_ready}, {31'd0, (!m_vld || out_ready)});
    chk({tag, ".outvalid"}, {31'd0, out_valid}, {31'd0, m_vld});
    if (m_vld || m_ill_det)
      chk({tag, ".illegal"}, {31'd0, ill_q}, {31'd0, m_ill});
    if (m_vld || m_det) begin
      chk({tag, ".a"}, {8'd0, a_q}, {8'd0, m_a});
      chk({tag, ".b"}, {8'd0, b_q}, {8'd0, m_b});
      chk({tag, ".op"}, {29'd0, op_q}, {29'd0, m_op});
      chk({tag, ".binv"}, {31'd0, binv_q}, {31'd0, m_binv});
      chk({tag, ".cin"}, {31'd0, cin_q}, {31'd0, m_cin});
    end
  endtask

  // Inputs for this cycle are already driven: check, then advance the model across the edge.
  task automatic cycle(input string tag);
    logic acc;
    #1;
    check_model(tag);
    acc = in_valid && (!m_vld || out_ready) && !flush;
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_a = 0; m_b = 0; m_op = 0; m_binv = 0; m_cin = 0; m_ill = 0;
      m_det = 1; m_ill_det = 1;
    end else if (flush) begin
      m_vld = 0; m_ill = 0; m_det = 0; m_ill_det = 1;
    end else if (acc) begin
      m_vld = 1; m_a = reg_a; m_b = use_imm ? sext12(imm) : reg_b;
      m_op = t_op[funct]; m_binv = t_binv[funct]; m_cin = t_cin[funct]; m_ill = t_ill[funct];
      m_det = 1; m_ill_det = 1;
    end else if (m_vld && out_ready) begin
      m_vld = 0; m_det = 0; m_ill_det = 0;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic ui,
                       input logic [23:0] ra, input logic [23:0] rb, input logic [11:0] im);
    in_valid = v; funct = f; use_imm = ui; reg_a = ra; reg_b = rb; imm = im;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      t_op[i] = 3'b000; t_binv[i] = 1'b0; t_cin[i] = 1'b0; t_ill[i] = (i > 5);
    end
    t_op[1] = 3'b001;
    t_op[2] = 3'b010;
    t_op[3] = 3'b010; t_binv[3] = 1'b1; t_cin[3] = 1'b1;
    t_op[4] = 3'b101;
    t_op[5] = 3'b011; t_binv[5] = 1'b1; t_cin[5] = 1'b1;

    m_vld = 0; m_ill = 0; m_binv = 0; m_cin = 0; m_det = 0; m_ill_det = 0;
    m_a = 0; m_b = 0; m_op = 0;
    rst = 1; flush = 0; out_ready = 1;
    drive(1, 4'd2, 0, 24'h123456, 24'h654321, 12'h0);

    // Reset held two cycles with InValid asserted; model checks are skipped until defined.
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_vld = 0; m_a = 0; m_b = 0; m_op = 0; m_binv = 0; m_cin = 0; m_ill = 0;
    m_det = 1; m_ill_det = 1;
    rst = 0;
    drive(0, 4'd0, 0, 24'h0, 24'h0, 12'h0);
    #1;
    chk("reset.outvalid", {31'd0, out_valid}, 32'd0);
    chk("reset.a", {8'd0, a_q}, 32'd0);
    chk("reset.b", {8'd0, b_q}, 32'd0);
    chk("reset.ctrl", {26'd0, op_q, binv_q, cin_q, ill_q}, 32'd0);
    chk("reset.inready", {31'd0, in_ready}, 32'd1);
    cycle("idle");

    // SUB with sign-extended immediate.
    drive(1, 4'd3, 1, 24'h000010, 24'h0000AA, 12'hFFF);
    cycle("sub.issue");
    drive(0, 4'd0, 0, 24'h0, 24'h0, 12'h0);
    out_ready = 0;
    #1;
    chk("sub.outvalid", {31'd0, out_valid}, 32'd1);
    chk("sub.a", {8'd0, a_q}, 32'h000010);
    chk("sub.b", {8'd0, b_q}, 32'hFFFFFF);
    chk("sub.ctrl", {28'd0, op_q, binv_q}, {28'd0, 3'b010, 1'b1});
    chk("sub.cin", {31'd0, cin_q}, 32'd1);

    // Stall three cycles with a pending AND.
    drive(1, 4'd0, 0, 24'h0F0F0F, 24'h00FF00, 12'h0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.b_held", {8'd0, b_q}, 32'hFFFFFF);
    end
    out_ready = 1;
    cycle("stall.release");
    chk("and.op", {29'd0, op_q}, 32'd0);
    chk("and.a", {8'd0, a_q}, 32'h0F0F0F);

    // Back-to-back stream ADD, OR, XOR, SLT.
    drive(1, 4'd2, 0, 24'h1, 24'h2, 12'h0); cycle("stream.add");
    chk("stream.add.op", {29'd0, op_q}, 32'b010);
    drive(1, 4'd1, 0, 24'h3, 24'h4, 12'h0); cycle("stream.or");
    chk("stream.or.op", {29'd0, op_q}, 32'b001);
    drive(1, 4'd4, 1, 24'h5, 24'h6, 12'h7FF); cycle("stream.xor");
    chk("stream.xor.op", {29'd0, op_q}, 32'b101);
    chk("stream.xor.b", {8'd0, b_q}, 32'h0007FF);
    drive(1, 4'd5, 0, 24'h7, 24'h8, 12'h0); cycle("stream.slt");
    chk("stream.slt.op", {29'd0, op_q}, 32'b011);
    chk("stream.slt.valid", {31'd0, out_valid}, 32'd1);

    // Undefined function code still issues, flagged illegal.
    drive(1, 4'd9, 0, 24'h9, 24'hA, 12'h0); cycle("illegal");
    chk("illegal.flag", {31'd0, ill_q}, 32'd1);
    chk("illegal.ctrl", {27'd0, out_valid, op_q, binv_q}, {27'd0, 1'b1, 3'b000, 1'b0});

    // Flush while full with a new instruction offered.
    out_ready = 0;
    drive(1, 4'd2, 0, 24'hB, 24'hC, 12'h0);
    flush = 1;
    cycle("flush");
    flush = 0;
    drive(0, 4'd0, 0, 24'h0, 24'h0, 12'h0);
    #1;
    chk("flush.outvalid", {31'd0, out_valid}, 32'd0);
    chk("flush.illegal", {31'd0, ill_q}, 32'd0);

    // Reset and Flush together with an illegal entry held.
    out_ready = 1;
    drive(1, 4'd12, 0, 24'hD, 24'hE, 12'h0); cycle("refill");
    out_ready = 0; flush = 1; rst = 1;
    cycle("rst_flush");
    rst = 0; flush = 0;
    #1;
    chk("rst_flush.state", {5'd0, out_valid, a_q, op_q, ill_q}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom),
            24'($urandom), 24'($urandom), 12'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 63) == 0;
      cycle("rand");
    end
    rst = 0; flush = 0; in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 24-bit ALU built from 1-bit slices.
- Accepts decoded instruction fields and register operands, then selects the B operand (register or sign-extended immediate).
- Translates the ALU function code into the slice controls Op[2:0], BInvert and CIN.
- Holds the result in a registered valid/ready stage feeding the ALU, with stall and flush support.

Parameters:
- WIDTH, 24, datapath width of A/B.
- IMM_WIDTH, 12, width of the immediate field before sign extension.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  upstream presents a valid instruction.
- InReady  output  1  stage can accept this cycle.
- Flush  input  1  discard the held entry and the incoming one (branch/exception).
- AluFunct  input  4  function code.
- UseImm  input  1  1 selects the sign-extended immediate as B.
- RegA  input  WIDTH  source operand A.
- RegB  input  WIDTH  source operand B.
- Imm  input  IMM_WIDTH  immediate field.
- OutValid  output  1  registered entry valid toward the ALU.
- OutReady  input  1  ALU/next stage consumes this cycle.
- A  output  WIDTH  registered operand A.
- B  output  WIDTH  registered operand B (not inverted; the slices perform inversion).
- Op  output  3  slice op select: 000 AND, 001 OR, 010 ADD, 011 SLT, 101 XOR.
- BInvert  output  1  slice B-invert control.
- CIN  output  1  carry-in to bit 0.
- Illegal  output  1  registered flag: held entry had an undefined AluFunct.

Behaviour:
- Reset (synchronous): OutValid=0, A=0, B=0, Op=000, BInvert=0, CIN=0, Illegal=0. Reset overrides Flush and any handshake in the same cycle.
- InReady = ~OutValid | OutReady. This path is combinational, with no registered bubble.
- Accept = InValid & InReady & ~Flush.
- On accept, the registers load on the next edge:
  - A=RegA.
  - B = UseImm ? sign-extend(Imm) to WIDTH : RegB. Imm[IMM_WIDTH-1] is replicated into the upper bits.
  - Decode AluFunct:
    - 0 AND: Op=000, BInvert=0, CIN=0.
    - 1 OR: Op=001, BInvert=0, CIN=0.
    - 2 ADD: Op=010, BInvert=0, CIN=0.
    - 3 SUB: Op=010, BInvert=1, CIN=1.
    - 4 XOR: Op=101, BInvert=0, CIN=0.
    - 5 SLT: Op=011, BInvert=1, CIN=1. The ALU forms the Less bit from the subtraction.
    - 6-15: Op=000, BInvert=0, CIN=0, Illegal=1, OutValid=1. The entry is still passed so that downstream raises the exception.
  - OutValid=1.
- Hold: when OutValid & ~OutReady & ~Flush, every output register keeps its value (stall). A, B, Op, BInvert, CIN and Illegal must stay stable for the whole stall.
- Drain: when OutValid & OutReady with no accept, the next state is OutValid=0. The data registers may keep stale values, which are don't-care while OutValid=0.
- Simultaneous drain and accept: the new entry loads the same edge, giving back-to-back throughput of 1/cycle.
- Flush: the next state is OutValid=0 and Illegal=0, whatever InValid, OutReady and the current state are. The incoming instruction is dropped, and InReady stays at its normal value.
- Latency: one cycle from accept to OutValid.
- There are no other states. The block is effectively a 2-state FSM: EMPTY (OutValid=0) and FULL (OutValid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept, or on Flush.
  - FULL→FULL on stall or on drain+accept.

Decomposition:
- Shared package holds:
  - Function codes FN_AND=0, FN_OR=1, FN_ADD=2, FN_SUB=3, FN_XOR=4, FN_SLT=5.
  - Slice op codes OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SLT=3'b011, OP_XOR=3'b101.
  - WIDTH default.
- One combinational sub-module, alu_control_decode: inputs AluFunct; outputs Op, BInvert, CIN, Illegal. The issue stage instantiates it and registers its outputs.

Test Plan:
- Reset then idle: assert Reset 2 cycles with InValid=1 → all outputs 0, InReady=1 after release.
- SUB with immediate: RegA=24'h000010, Imm=12'hFFF, UseImm=1, AluFunct=3, OutReady=1 → next cycle OutValid=1, A=24'h000010, B=24'hFFFFFF, Op=010, BInvert=1, CIN=1.
- Stall: entry held with OutReady=0 for 3 cycles while InValid=1 carries a new AND op → InReady=0, outputs unchanged. On OutReady=1 the AND entry loads next edge (Op=000) with no bubble.
- Back-to-back stream: ADD, OR, XOR, SLT on consecutive cycles with OutReady=1 → four consecutive OutValid cycles with Op=010, 001, 101, 011 in order.
- Illegal funct: AluFunct=9 → OutValid=1, Illegal=1, Op=000, BInvert=0, CIN=0.
- Flush: Flush=1 while FULL and InValid=1 → next cycle OutValid=0, Illegal=0, incoming entry absent. Also Flush and Reset together → reset values.
